// File: rtl/adder_error_accumulator.sv
// Accumulates error count, summed error distance and maximum error distance
// between exact and approximate adder sums over a window of SAMPLES accepted pairs.
module adder_error_accumulator #(
  parameter int WIDTH   = 8,
  parameter int SAMPLES = 256,
  parameter int CNT_W   = $clog2(SAMPLES + 1),
  parameter int SUM_W   = WIDTH + 1 + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   exact_sum,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] ed_sum,
  output logic [WIDTH:0]   max_ed
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sample_cnt;
  logic [WIDTH:0]   ed;
  logic             accept;
  logic             last;
  logic             clr;

  function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] a,
                                              input logic [WIDTH:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  assign in_ready = (state == ACCUM);
  assign busy     = (state == ACCUM);
  assign done     = (state == DONE);

  assign ed     = abs_diff(exact_sum, approx_sum);
  assign accept = in_valid && in_ready;
  assign last   = accept && (sample_cnt == CNT_W'(SAMPLES - 1));
  // start only opens a window outside ACCUM; a pair offered alongside it is not taken
  assign clr    = start && (state != ACCUM);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sample_cnt <= '0;
      err_count  <= '0;
      ed_sum     <= '0;
      max_ed     <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 1'b1;
      err_count  <= err_count + CNT_W'(ed != '0);
      ed_sum     <= ed_sum + SUM_W'(ed);
      if (ed > max_ed) max_ed <= ed;
    end
  end

endmodule
